// File: rtl/comparador_rnm_bank.sv
// N-channel clocked real-number-model comparator bank.
// Each channel applies an input offset and a hysteresis window, then debounces the result.
// A 4-state FSM produces a registered decision, an analog output level, edge pulses
// and a wrapping count of decision changes.
module comparador_rnm_bank #(
  parameter int  N_CH     = 4,
  parameter real HYST     = 0.01,
  parameter real OFFSET   = 0.0,
  parameter int  DEBOUNCE = 2,
  parameter real VDD      = 1.0,
  parameter int  CNT_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         en_i,
  input  real                     p_i [N_CH],
  input  real                     n_i [N_CH],
  output real                     c_o [N_CH],
  output logic [N_CH-1:0]         dec_o,
  output logic [N_CH-1:0]         rise_o,
  output logic [N_CH-1:0]         fall_o,
  output logic [N_CH*CNT_W-1:0]   tog_cnt_o
);

  // Wide enough to hold any value from 0 to DEBOUNCE.
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    PEND_H = 2'd1,
    HIGH   = 2'd2,
    PEND_L = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [DBW-1:0]   cnt_reg, cnt_next;
      logic             dec_reg, dec_next;
      logic             rise_reg, fall_reg;
      logic [CNT_W-1:0] tog_reg;
      logic             up, dn;
      real              d;

      // Offset-corrected differential input compared against the +/-HYST/2 window.
      always_comb begin
        d  = p_i[gi] - n_i[gi] - OFFSET;
        up = (d > HYST / 2.0);
        dn = (d < -HYST / 2.0);
      end

      // Next-state logic: disabling a channel aborts any pending transition.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!en_i[gi]) begin
          cnt_next = '0;
          if (state_reg == PEND_H) state_next = LOW;
          if (state_reg == PEND_L) state_next = HIGH;
        end else begin
          case (state_reg)
            LOW: begin
              if (up) begin
                if (DEBOUNCE == 1) begin
                  state_next = HIGH;
                  cnt_next   = '0;
                end else begin
                  state_next = PEND_H;
                  cnt_next   = DBW'(1);
                end
              end
            end
            PEND_H: begin
              if (!up) begin
                state_next = LOW;
                cnt_next   = '0;
              end else if (int'(cnt_reg) + 1 == DEBOUNCE) begin
                state_next = HIGH;
                cnt_next   = '0;
              end else begin
                cnt_next   = cnt_reg + 1'b1;
              end
            end
            HIGH: begin
              if (dn) begin
                if (DEBOUNCE == 1) begin
                  state_next = LOW;
                  cnt_next   = '0;
                end else begin
                  state_next = PEND_L;
                  cnt_next   = DBW'(1);
                end
              end
            end
            PEND_L: begin
              if (!dn) begin
                state_next = HIGH;
                cnt_next   = '0;
              end else if (int'(cnt_reg) + 1 == DEBOUNCE) begin
                state_next = LOW;
                cnt_next   = '0;
              end else begin
                cnt_next   = cnt_reg + 1'b1;
              end
            end
            default: begin
              state_next = LOW;
              cnt_next   = '0;
            end
          endcase
        end
        dec_next = (state_next == HIGH) || (state_next == PEND_L);
      end

      // State, decision, edge pulses and toggle counter; reset clears everything.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_reg <= LOW;
          cnt_reg   <= '0;
          dec_reg   <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          tog_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          dec_reg   <= dec_next;
          rise_reg  <= dec_next & ~dec_reg;
          fall_reg  <= ~dec_next & dec_reg;
          if (dec_next != dec_reg) tog_reg <= tog_reg + 1'b1;
        end
      end

      assign dec_o[gi]                     = dec_reg;
      assign rise_o[gi]                    = rise_reg;
      assign fall_o[gi]                    = fall_reg;
      assign tog_cnt_o[gi*CNT_W +: CNT_W]  = tog_reg;
    end
  endgenerate

  // Analog output level follows the registered decision.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      c_o[k] = dec_o[k] ? VDD : 0.0;
    end
  end

endmodule
